register_wb: RTL and testbench
==============================

REGISTER_WB -- requirements
Module: register_wb

Interface
REQ-001 Parameter WB_DEPTH, default 4, number of pending-write queue entries (power of two, at least 2).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 lsu_valid / lsu_waddr / lsu_wdata  in  1/5/32  load-unit writeback request.
REQ-005 lsu_ready  out  1  load-unit request accepted this cycle when lsu_valid=1.
REQ-006 alu_valid / alu_waddr / alu_wdata  in  1/5/32  ALU writeback request.
REQ-007 alu_ready  out  1  ALU request accepted this cycle when alu_valid=1.
REQ-008 raddr1 / raddr2  in  5/5  decode-stage read addresses for bypass lookup.
REQ-009 hit1 / hit2  out  1/1  a pending write to raddrN exists.
REQ-010 fdata1 / fdata2  out  32/32  youngest pending data for raddrN; 0 when no hit.
REQ-011 register_win  out  register_win_type  (wren, waddr[4:0], wdata[31:0]) to the register-file write port.
REQ-012 count  out  $clog2(WB_DEPTH)+1  current queue occupancy.

Function
REQ-013 The block SHALL be the sole driver of the register-file write port, serialising two writeback sources through an in-order FIFO of WB_DEPTH entries.
REQ-014 free = WB_DEPTH - count, taken from the registered count before this cycle's pop (no same-cycle pop credit).
REQ-015 lsu_ready = (free >= 1); alu_ready = (free >= 2) when lsu_valid=1, else (free >= 1); neither depends on waddr or wdata.
REQ-016 With both accepted in one cycle, the LSU entry SHALL be enqueued before the ALU entry (LSU is the older instruction).
REQ-017 An accepted request with waddr=0 SHALL be dropped: handshake completes, no entry is enqueued, count is not incremented.
REQ-018 When count>0, register_win SHALL present the head entry combinationally with wren=1, and the head SHALL pop at the next rising edge (one write per cycle, no stall input).
REQ-019 When count=0, register_win SHALL output wren=0, waddr=0, wdata=0.
REQ-020 Latency: a request accepted at edge N appears on register_win at the earliest in cycle N+1 if the queue was empty.
REQ-021 Next count = count + enqueues (0..2) - pop (0/1); push and pop in the same cycle are legal at every occupancy, including full.
REQ-022 Read and write pointers SHALL wrap modulo WB_DEPTH.
REQ-023 hitN=1 iff raddrN != 0 and any occupied entry, including the head being written this cycle, has waddr == raddrN.
REQ-024 fdataN SHALL return the youngest matching entry; requests arriving in the current cycle are not visible to lookup.
REQ-025 hitN and fdataN SHALL be purely combinational from queue state and raddrN.

Reset
REQ-026 While rst=0 at a rising edge: pointers=0, count=0, all entry valid flags cleared; entry data need not be cleared.
REQ-027 During and after reset: wren=0, hit1=hit2=0, fdata1=fdata2=0, lsu_ready=alu_ready=1.
REQ-028 A reset asserted mid-operation SHALL discard all pending writes; none reaches register_win afterwards.

Structure
REQ-029 register_win_type already exists in package wires; the package SHALL add wb_entry_type (waddr, wdata) and constant WB_DEPTH=4.
REQ-030 One sub-module, wb_fifo (2-write/1-read circular buffer exposing all entries for lookup), is natural; the bypass priority search stays in register_wb.
REQ-031 The register file is not modified; its write port is driven only through register_win.

Verification
REQ-032 Single write: alu x5=0xDEADBEEF into empty queue -> next cycle wren=1, waddr=5, wdata=0xDEADBEEF; following cycle wren=0, count=0.
REQ-033 Dual accept: lsu x1=0x11 and alu x2=0x22 in the same cycle -> two consecutive writes, x1 then x2; count peaks at 2.
REQ-034 Backpressure: with count=3 (WB_DEPTH=4) and both valid -> lsu_ready=1, alu_ready=0; ALU accepted the next cycle after the pop.
REQ-035 Bypass: queue holds x7=0xA then x7=0xB, raddr1=7 -> hit1=1, fdata1=0xB; raddr2=0 -> hit2=0, fdata2=0.
REQ-036 x0 drop: alu x0=0xFFFF accepted -> count stays 0, wren never asserted for it.
REQ-037 Reset mid-op: 3 entries pending, rst=0 for one edge -> count=0 and wren=0 from the next cycle, no queued write ever emitted.

Source files
------------

// File: rtl/wires_pkg.sv
// Shared writeback wiring types: the register-file write port and the
// pending-write queue entry used between the two writeback sources and the RF.
package wires;

    typedef struct packed {
        logic        wren;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } register_win_type;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_entry_type;

    localparam int WB_DEPTH = 4;

endpackage

// File: rtl/register_wb_fifo.sv
// Two-write / one-read circular buffer of pending register writes; every
// slot and its valid flag is exposed so the owner can run a bypass search.
module wb_fifo
    import wires::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0,
    input  wb_entry_type               entry0,
    input  logic                       push1,
    input  wb_entry_type               entry1,
    input  logic                       pop,
    output wb_entry_type               entries [DEPTH],
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_type     mem_q [DEPTH];
    wb_entry_type     mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_next;

    // push1 is only ever asserted together with push0, so it lands in the slot after it
    always_comb begin
        mem_d       = mem_q;
        valid_d     = valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_next = wr_ptr_q + AW'(1);
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
        end
        if (push0) begin
            mem_d[wr_ptr_q]   = entry0;
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (push1) begin
            mem_d[wr_ptr_next]   = entry1;
            valid_d[wr_ptr_next] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign entries = mem_q;
    assign valid   = valid_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = count_q;

endmodule

// File: rtl/register_wb.sv
// Sole driver of the register-file write port: merges LSU and ALU writebacks
// into one in-order queue and offers a youngest-first bypass for decode reads.
module register_wb
    import wires::*;
#(
    parameter int WB_DEPTH = wires::WB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lsu_valid,
    input  logic [4:0]                  lsu_waddr,
    input  logic [31:0]                 lsu_wdata,
    output logic                        lsu_ready,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_waddr,
    input  logic [31:0]                 alu_wdata,
    output logic                        alu_ready,
    input  logic [4:0]                  raddr1,
    input  logic [4:0]                  raddr2,
    output logic                        hit1,
    output logic                        hit2,
    output logic [31:0]                 fdata1,
    output logic [31:0]                 fdata2,
    output register_win_type            register_win,
    output logic [$clog2(WB_DEPTH):0]   count
);

    localparam int AW = $clog2(WB_DEPTH);
    localparam int CW = AW + 1;

    wb_entry_type        entries [WB_DEPTH];
    logic [WB_DEPTH-1:0] valid;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       occ;
    logic [CW-1:0]       free;
    logic                lsu_push, alu_push, push0, push1, pop;
    wb_entry_type        lsu_entry, alu_entry, entry0;
    logic [AW-1:0]       idx;

    // Credit comes from the registered occupancy only; a same-cycle pop frees nothing
    always_comb begin
        free      = CW'(WB_DEPTH) - occ;
        lsu_ready = !rst || (free >= CW'(1));
        alu_ready = !rst || (lsu_valid ? (free >= CW'(2)) : (free >= CW'(1)));
        lsu_push  = rst && lsu_valid && lsu_ready && (lsu_waddr != 5'd0);
        alu_push  = rst && alu_valid && alu_ready && (alu_waddr != 5'd0);
        lsu_entry = '{waddr: lsu_waddr, wdata: lsu_wdata};
        alu_entry = '{waddr: alu_waddr, wdata: alu_wdata};
        push0     = lsu_push || alu_push;
        push1     = lsu_push && alu_push;
        entry0    = lsu_push ? lsu_entry : alu_entry;
        pop       = rst && (occ != '0);
    end

    wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0   (push0),
        .entry0  (entry0),
        .push1   (push1),
        .entry1  (alu_entry),
        .pop     (pop),
        .entries (entries),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .count   (occ)
    );

    always_comb begin
        register_win = '0;
        if (pop) begin
            register_win.wren  = 1'b1;
            register_win.waddr = entries[rd_ptr].waddr;
            register_win.wdata = entries[rd_ptr].wdata;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        fdata1 = '0;
        fdata2 = '0;
        idx    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (rst && valid[idx] && raddr1 != 5'd0 && entries[idx].waddr == raddr1) begin
                hit1   = 1'b1;
                fdata1 = entries[idx].wdata;
            end
            if (rst && valid[idx] && raddr2 != 5'd0 && entries[idx].waddr == raddr2) begin
                hit2   = 1'b1;
                fdata2 = entries[idx].wdata;
            end
        end
    end

    assign count = occ;

endmodule

// File: tb/tb_register_wb.sv
// Randomized self-checking bench for register_wb against a queue-based model
// of the pending-write list, plus the directed scenarios of interest.
module tb_register_wb;
    import wires::*;

    localparam int D = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             lsu_valid, alu_valid;
    logic [4:0]       lsu_waddr, alu_waddr, raddr1, raddr2;
    logic [31:0]      lsu_wdata, alu_wdata;
    logic             lsu_ready, alu_ready, hit1, hit2;
    logic [31:0]      fdata1, fdata2;
    register_win_type register_win;
    logic [2:0]       count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } pend_t;

    pend_t model_q[$];
    int    checks = 0;
    int    errors = 0;

    register_wb #(.WB_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_valid    (lsu_valid),
        .lsu_waddr    (lsu_waddr),
        .lsu_wdata    (lsu_wdata),
        .lsu_ready    (lsu_ready),
        .alu_valid    (alu_valid),
        .alu_waddr    (alu_waddr),
        .alu_wdata    (alu_wdata),
        .alu_ready    (alu_ready),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .hit1         (hit1),
        .hit2         (hit2),
        .fdata1       (fdata1),
        .fdata2       (fdata2),
        .register_win (register_win),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Youngest pending write to address a, as seen from the model list
    task automatic lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0)
            foreach (model_q[i])
                if (model_q[i].a == a) begin
                    h = 1'b1;
                    d = model_q[i].d;
                end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic applyStimulus(input logic r,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic [4:0] r1, input logic [4:0] r2);
        int          free;
        logic        exp_lr, exp_ar, eh1, eh2;
        logic [31:0] ed1, ed2;
        pend_t       e;
        @(negedge clk);
        rst = r; lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad; raddr1 = r1; raddr2 = r2;
        #1;
        free   = D - model_q.size();
        exp_lr = !r || free >= 1;
        exp_ar = !r || (lv ? free >= 2 : free >= 1);
        lookup(r1, eh1, ed1);
        lookup(r2, eh2, ed2);
        if (!r) begin
            eh1 = 0; eh2 = 0; ed1 = 0; ed2 = 0;
        end
        checkOutput("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
        checkOutput("alu_ready", 32'(alu_ready), 32'(exp_ar));
        checkOutput("hit1", 32'(hit1), 32'(eh1));
        checkOutput("fdata1", fdata1, ed1);
        checkOutput("hit2", 32'(hit2), 32'(eh2));
        checkOutput("fdata2", fdata2, ed2);
        if (r && model_q.size() > 0) begin
            checkOutput("wren", 32'(register_win.wren), 32'd1);
            checkOutput("waddr", 32'(register_win.waddr), 32'(model_q[0].a));
            checkOutput("wdata", register_win.wdata, model_q[0].d);
        end else begin
            checkOutput("wren", 32'(register_win.wren), 32'd0);
            checkOutput("waddr", 32'(register_win.waddr), 32'd0);
            checkOutput("wdata", register_win.wdata, 32'd0);
        end
        if (r)
            checkOutput("count", 32'(count), 32'(model_q.size()));
        @(posedge clk);
        if (!r) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0)
                void'(model_q.pop_front());
            if (lv && exp_lr && la != 5'd0) begin
                e.a = la; e.d = ld; model_q.push_back(e);
            end
            if (av && exp_ar && aa != 5'd0) begin
                e.a = aa; e.d = ad; model_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++)
            applyStimulus(1, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        rst = 0; lsu_valid = 0; alu_valid = 0; lsu_waddr = 0; alu_waddr = 0;
        lsu_wdata = 0; alu_wdata = 0; raddr1 = 0; raddr2 = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        // single write into an empty queue
        applyStimulus(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        idle(2, 5, 0);

        // dual accept, LSU first
        applyStimulus(1, 1, 1, 32'h11, 1, 2, 32'h22, 1, 2);
        idle(3, 1, 2);

        // fill to three, then backpressure the ALU and retry
        applyStimulus(1, 1, 3, 32'h33, 1, 4, 32'h44, 3, 4);
        applyStimulus(1, 1, 6, 32'h66, 1, 8, 32'h88, 6, 8);
        applyStimulus(1, 1, 9, 32'h99, 1, 10, 32'hAA, 9, 10);
        applyStimulus(1, 0, 0, 0, 1, 10, 32'hAA, 10, 4);
        idle(5, 10, 0);

        // bypass returns the younger of two writes to the same register
        applyStimulus(1, 1, 7, 32'hA, 1, 7, 32'hB, 7, 0);
        idle(3, 7, 0);

        // writes to x0 are dropped
        applyStimulus(1, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        idle(2, 0, 0);

        // reset with writes pending
        applyStimulus(1, 1, 11, 32'h1, 1, 12, 32'h2, 0, 0);
        applyStimulus(1, 1, 13, 32'h3, 1, 14, 32'h4, 11, 14);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 13, 14);
        idle(4, 13, 14);

        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 59) != 0),
                          ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                          ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
